// File: rtl/wishbone_interconnect_sync.sv
// Single-controller Wishbone classic interconnect with registered routing,
// unmapped-address error, ack timeout and abort on dropped cyc.
module wishbone_interconnect_sync #(
    parameter int PERIPH_NUM    = 4,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 16,
    parameter int PERIPH_ADDR_W = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst,
    input  logic                         wbc_cyc,
    input  logic                         wbc_stb,
    input  logic                         wbc_we,
    input  logic [ADDR_W-1:0]            wbc_adr,
    input  logic [DATA_W/8-1:0]          wbc_sel,
    input  logic [DATA_W-1:0]            wbc_dat_c,
    output logic [DATA_W-1:0]            wbc_dat_p,
    output logic                         wbc_ack,
    output logic                         wbc_err,
    output logic [PERIPH_NUM-1:0]        wbp_cyc,
    output logic [PERIPH_NUM-1:0]        wbp_stb,
    output logic                         wbp_we,
    output logic [PERIPH_ADDR_W-1:0]     wbp_adr,
    output logic [DATA_W/8-1:0]          wbp_sel,
    output logic [DATA_W-1:0]            wbp_dat_c,
    input  logic [PERIPH_NUM*DATA_W-1:0] wbp_dat_p,
    input  logic [PERIPH_NUM-1:0]        wbp_ack
);

    localparam int IDX_W  = ADDR_W - PERIPH_ADDR_W;
    localparam int PIDX_W = (PERIPH_NUM > 1) ? $clog2(PERIPH_NUM) : 1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESPOND,
        ERROR
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PIDX_W-1:0]   idx_q;
    logic [15:0]         cnt_q;
    logic [IDX_W-1:0]    req_idx;
    logic                req;
    logic                req_hit;
    logic                sel_ack;
    logic                timeout;
    logic [DATA_W-1:0]   sel_dat;

    assign req     = wbc_cyc && wbc_stb;
    assign req_idx = wbc_adr[ADDR_W-1:PERIPH_ADDR_W];
    assign req_hit = 32'(req_idx) < 32'(PERIPH_NUM);
    assign timeout = (cnt_q == CNT_LAST);

    // Only the latched peripheral may respond; others are never looked at.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < PERIPH_NUM; i++) begin
            if (idx_q == PIDX_W'(i)) begin
                sel_ack = wbp_ack[i];
                sel_dat = wbp_dat_p[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = req_hit ? ACTIVE : ERROR;
                end
            end
            ACTIVE: begin
                if (!wbc_cyc) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    state_d = RESPOND;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            RESPOND: state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request attributes are frozen at acceptance so the peripheral
    // sees stable values even if the controller changes its bus.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            wbp_we    <= 1'b0;
            wbp_adr   <= '0;
            wbp_sel   <= '0;
            wbp_dat_c <= '0;
            wbc_dat_p <= '0;
        end else begin
            if (state_q == IDLE && req && req_hit) begin
                idx_q     <= PIDX_W'(req_idx);
                cnt_q     <= '0;
                wbp_we    <= wbc_we;
                wbp_adr   <= wbc_adr[PERIPH_ADDR_W-1:0];
                wbp_sel   <= wbc_sel;
                wbp_dat_c <= wbc_dat_c;
            end
            if (state_q == ACTIVE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == ACTIVE && wbc_cyc && sel_ack) begin
                wbc_dat_p <= sel_dat;
            end
        end
    end

    always_comb begin
        wbp_cyc = '0;
        wbc_ack = 1'b0;
        wbc_err = 1'b0;
        unique case (state_q)
            ACTIVE:  wbp_cyc[idx_q] = 1'b1;
            RESPOND: wbc_ack = 1'b1;
            ERROR:   wbc_err = 1'b1;
            default: ;
        endcase
    end

    assign wbp_stb = wbp_cyc;

endmodule
